// File: rtl/sqrt_seq.sv
// sqrt_seq - sequential fixed-point square root (restoring, one root bit
// per clock) used to turn a variance into a standard deviation.
//
// Operand and result are Q(WIDTH-FBITS).FBITS two's-complement. The root
// has ITER = (WIDTH+FBITS)/2 bits and is zero-extended onto out_data.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data carries an operand
//   in_ready   unit is idle and will take an operand
//   in_data    variance, signed Q12.20 (default parameters)
//   out_valid  out_data / out_neg carry a result
//   out_ready  downstream takes the result
//   out_data   sqrt(in_data), Q12.20, 0 for a negative operand
//   out_neg    the operand was negative
//
// Build option
//   SQRT_ROUND_EN  defined: round the root to nearest at the final
//                  iteration. Undefined (default): truncate.
module sqrt_seq #(
  parameter int WIDTH = 32,
  parameter int FBITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_neg
);

  localparam int ITER  = (WIDTH + FBITS) / 2;
  localparam int RAD_W = 2 * ITER;
  localparam int REM_W = ITER + 2;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem;
  logic [ITER-1:0]  root;
  logic [CNT_W-1:0] cnt;

  logic signed [WIDTH-1:0] operand;
  logic                    neg;
  logic                    accept;
  logic                    last_iter;
  logic [RAD_W-1:0]        rad_load;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             take;
  logic [REM_W-1:0] rem_nx;
  logic [ITER-1:0]  root_nx;
  logic [ITER-1:0]  root_fin;

  // The top two remainder bits are always zero entering an iteration
  // (remainder <= 2*root), so they are never shifted onward.
  logic unused_rem_hi;
  assign unused_rem_hi = ^rem[REM_W-1:ITER];

`ifdef SQRT_ROUND_EN
  // Round to nearest: N - r^2 > r means sqrt(N) lies above r + 1/2.
  function automatic logic [ITER-1:0] round_root(input logic [ITER-1:0]  r,
                                                 input logic [REM_W-1:0] rm);
    if (rm > REM_W'(r)) begin
      return r + ITER'(1);
    end
    return r;
  endfunction
`endif

  assign operand   = in_data;
  assign neg       = operand < 0;
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == '0);
  assign rad_load  = RAD_W'({in_data[WIDTH-2:0], {FBITS{1'b0}}});

  // One restoring iteration: bring down two radicand bits, try {root,01}.
  always_comb begin
    rem_sh  = {rem[ITER-1:0], rad[RAD_W-1 -: 2]};
    trial   = {root, 2'b01};
    take    = (rem_sh >= trial);
    rem_nx  = take ? (rem_sh - trial) : rem_sh;
    root_nx = {root[ITER-2:0], take};
`ifdef SQRT_ROUND_EN
    root_fin = round_root(root_nx, rem_nx);
`else
    root_fin = root_nx;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)    state_nx = CALC;
      CALC: if (last_iter) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. A negative operand is loaded as a zero radicand with the
  // counter already at zero: its single CALC pass yields a root of 0 and
  // puts out_valid up one cycle after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_neg  <= 1'b0;
    end else if (accept) begin
      rad      <= neg ? '0 : rad_load;
      rem      <= '0;
      root     <= '0;
      cnt      <= neg ? '0 : CNT_W'(ITER - 1);
      out_data <= '0;
      out_neg  <= neg;
    end else if (state == CALC) begin
      rad  <= {rad[RAD_W-3:0], 2'b00};
      rem  <= rem_nx;
      root <= root_nx;
      if (last_iter) begin
        out_data <= WIDTH'(root_fin);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed bench for sqrt_seq: reset values, exact/rounded/maximum roots,
// negative and zero operands, latency, back-pressure, blocked second
// operand during CALC, and reset in mid-calculation.
module tb_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;

  int tests = 0;
  int fails = 0;
  int n;

`ifdef SQRT_ROUND_EN
  localparam logic [31:0] EXP_THREE = 32'h0000_06EE;
  localparam logic [31:0] EXP_MAX   = 32'h02D4_13CD;
`else
  localparam logic [31:0] EXP_THREE = 32'h0000_06ED;
  localparam logic [31:0] EXP_MAX   = 32'h02D4_13CC;
`endif

  sqrt_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_neg  (out_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an operand at a falling edge, let it be accepted at the next
  // rising edge, then scramble in_data to show it is not sampled again.
  task automatic send(input logic [31:0] d);
    @(negedge clk);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after consume", 32'(out_valid), 32'd0);
    check("in_ready after consume", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset out_neg", 32'(out_neg), 32'd0);
    rst = 1'b0;

    // 4.0 -> 2.0
    send(32'h0040_0000);
    wait_done(n);
    check("latency 4.0", 32'(n), 32'd26);
    check("root 4.0", out_data, 32'h0020_0000);
    check("neg 4.0", 32'(out_neg), 32'd0);
    consume();

    // smallest-scale value, rounding sensitive
    send(32'h0000_0003);
    wait_done(n);
    check("latency 3 lsb", 32'(n), 32'd26);
    check("root 3 lsb", out_data, EXP_THREE);
    consume();

    // largest positive operand
    send(32'h7FFF_FFFF);
    wait_done(n);
    check("root max", out_data, EXP_MAX);
    check("neg max", 32'(out_neg), 32'd0);
    consume();

    // negative operand
    send(32'hFFF0_0000);
    wait_done(n);
    check("latency negative", 32'(n), 32'd1);
    check("neg negative", 32'(out_neg), 32'd1);
    check("root negative", out_data, 32'd0);
    consume();

    // zero operand runs the full sequence
    send(32'h0000_0000);
    wait_done(n);
    check("latency zero", 32'(n), 32'd26);
    check("root zero", out_data, 32'd0);
    check("neg zero", 32'(out_neg), 32'd0);
    consume();

    // back-pressure: 9.0 -> 3.0 held for 10 cycles
    send(32'h0090_0000);
    wait_done(n);
    check("root 9.0", out_data, 32'h0030_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_data", out_data, 32'h0030_0000);
      check("stall in_ready", 32'(in_ready), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    consume();

    // second operand offered during CALC must wait for the consume
    send(32'h0040_0000);
    in_valid = 1'b1;
    in_data  = 32'h0010_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("calc in_ready", 32'(in_ready), 32'd0);
    end
    wait_done(n);
    check("first result kept", out_data, 32'h0020_0000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready after handshake", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(n);
    check("latency second", 32'(n), 32'd26);
    check("root second", out_data, 32'h0010_0000);
    consume();

    // reset during CALC
    send(32'h0040_0000);
    repeat (11) @(negedge clk);
    check("mid-calc out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("reset mid-calc in_ready", 32'(in_ready), 32'd1);
    check("reset mid-calc out_valid", 32'(out_valid), 32'd0);
    check("reset mid-calc out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'h0010_0000);
    wait_done(n);
    check("latency after reset", 32'(n), 32'd26);
    check("root after reset", out_data, 32'h0010_0000);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
